instr_sequencer: RTL and testbench

Program store and run controller that feeds `simple_cpu`'s `instruction` input. A host loads up to 2^PC_BITS instruction words. On `start`, the block issues them in order, holding each word for a fixed number of cycles so the CU can complete its multi-cycle execution. It supports free-running and single-step modes, abort, and a completion pulse, and is the only driver of the CPU instruction bus.

---
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_instr_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Program store and run controller feeding simple_cpu's instruction input.
//   A host loads up to 2^PC_BITS words while idle. On start the words are
//   issued in order, each held for STEP_CYCLES cycles, either back-to-back
//   (free-run) or with a PAUSE between words released by step (single-step).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   load_en      write load_data to the store at load_addr (rejected while busy)
//   load_addr    store write address
//   load_data    store write data
//   start        begin a run (IDLE only)
//   prog_len     number of words to issue, clamped to 2^PC_BITS
//   single_step  step-mode select, sampled with start
//   step         release the next word from PAUSE
//   abort        terminate a run in RUN/PAUSE
//   instruction  word driven to the CPU (NOP_INSTR when nothing is issued)
//   pc           index of the word currently issued
//   busy         high in RUN and PAUSE
//   done         one-cycle pulse on normal completion
//   aborted      one-cycle pulse when a run ends by abort
//   load_err     one-cycle pulse when a load is rejected
module instr_sequencer #(
    parameter int unsigned             INSTR_WIDTH = 20,
    parameter int unsigned             PC_BITS     = 5,
    parameter int unsigned             STEP_CYCLES = 4,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   start,
    input  logic [PC_BITS:0]       prog_len,
    input  logic                   single_step,
    input  logic                   step,
    input  logic                   abort,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   load_err
);

    localparam int unsigned DEPTH = 1 << PC_BITS;
    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [PC_BITS:0] DEPTH_LEN = (PC_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [PC_BITS:0]       len;
    logic                   step_mode;
    logic                   last_word;

    // Store is deliberately left out of reset so a program survives rst.
    // busy is the registered RUN/PAUSE flag, so a write accepted in the
    // same IDLE cycle as start is visible to the first fetch.
    always_ff @(posedge clk) begin
        if (load_en && !busy)
            mem[load_addr] <= load_data;
    end

    assign last_word   = ({1'b0, pc} == (len - (PC_BITS + 1)'(1)));
    assign instruction = (state == S_RUN) ? mem[pc] : NOP_INSTR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            cnt       <= '0;
            len       <= '0;
            step_mode <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            done     <= 1'b0;
            aborted  <= 1'b0;
            load_err <= load_en && busy;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len       <= (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
                        step_mode <= single_step;
                        pc        <= '0;
                        cnt       <= '0;
                        if (prog_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        pc      <= '0;
                        cnt     <= '0;
                    end else if (cnt == CNT_LAST) begin
                        if (last_word) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            pc  <= pc + 1'b1;
                            cnt <= '0;
                            if (step_mode)
                                state <= S_PAUSE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        pc      <= '0;
                        cnt     <= '0;
                    end else if (step) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer
//   Scoreboard bench for instr_sequencer. Each stimulus step pushes the
//   expected per-cycle outputs (tagged with the cycle they belong to) onto a
//   queue; a negedge monitor pops and compares them as the cycles arrive.
module tb_instr_sequencer;

    localparam int IW = 20;
    localparam int PB = 5;
    localparam int S  = 4;
    localparam logic [IW-1:0] NOP = 20'h00000;
    localparam int BIG = 32'h7fffffff;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0;
    logic [PB-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic [PB:0]   prog_len = '0;
    logic          single_step = 1'b0;
    logic          step = 1'b0;
    logic          abort = 1'b0;
    logic [IW-1:0] instruction;
    logic [PB-1:0] pc;
    logic          busy, done, aborted, load_err;

    instr_sequencer #(
        .INSTR_WIDTH (IW),
        .PC_BITS     (PB),
        .STEP_CYCLES (S),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .prog_len    (prog_len),
        .single_step (single_step),
        .step        (step),
        .abort       (abort),
        .instruction (instruction),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int            c;
        logic [IW-1:0] instr;
        int            pc;      // -1: not checked
        logic          busy;
        logic          done;
        logic          aborted;
        logic          load_err;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [IW-1:0] prog [32];
    int            gap [32];
    int            step_at[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [IW-1:0] i, input int p,
                        input logic b, input logic d, input logic a);
        exp_t e;
        e.c = c; e.instr = i; e.pc = p;
        e.busy = b; e.done = d; e.aborted = a; e.load_err = 1'b0;
        sb.push_back(e);
    endtask

    task automatic set_err(input int c);
        foreach (sb[i]) if (sb[i].c == c) sb[i].load_err = 1'b1;
    endtask

    // Expected trace of a run whose start was sampled at edge e: words from
    // cycle e, STEP_CYCLES each, gap[w] PAUSE cycles after word w in step
    // mode, then the done cycle and one idle cycle. Nothing past 'last'.
    task automatic push_run(input int e, input int n, input bit smode,
                            input int last, output int done_c);
        int c;
        c = e;
        step_at.delete();
        for (int w = 0; w < n; w++) begin
            if (smode && w > 0) step_at.push_back(c);
            for (int j = 0; j < S; j++) begin
                if (c <= last) push(c, prog[w], w, 1'b1, 1'b0, 1'b0);
                c++;
            end
            if (smode && w < n - 1) begin
                for (int g = 0; g < gap[w]; g++) begin
                    if (c <= last) push(c, NOP, w + 1, 1'b1, 1'b0, 1'b0);
                    c++;
                end
            end
        end
        done_c = c;
        if (c <= last) push(c, NOP, -1, 1'b0, 1'b1, 1'b0);
        c++;
        if (c <= last) push(c, NOP, -1, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.c < cyc) begin
                chk($sformatf("late_c%0d", mon_e.c), cyc, mon_e.c);
            end else begin
                chk($sformatf("c%0d_instr", mon_e.c), instruction, mon_e.instr);
                if (mon_e.pc >= 0) chk($sformatf("c%0d_pc", mon_e.c), pc, mon_e.pc);
                chk($sformatf("c%0d_busy", mon_e.c), busy, mon_e.busy);
                chk($sformatf("c%0d_done", mon_e.c), done, mon_e.done);
                chk($sformatf("c%0d_aborted", mon_e.c), aborted, mon_e.aborted);
                chk($sformatf("c%0d_load_err", mon_e.c), load_err, mon_e.load_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic load_word(input int a, input logic [IW-1:0] d);
        load_en   = 1'b1;
        load_addr = a[PB-1:0];
        load_data = d;
        prog[a]   = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_start(input int len, input bit sm, output int e);
        prog_len    = len[PB:0];
        single_step = sm;
        start       = 1'b1;
        e           = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_instr"},    instruction, NOP);
        chk({tag, "_pc"},       pc, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_done"},     done, 0);
        chk({tag, "_aborted"},  aborted, 0);
        chk({tag, "_load_err"}, load_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e, dc;
        foreach (gap[i]) gap[i] = 1;

        // Reset state
        #3;
        chk_reset_outputs("rst");
        tick(); tick();
        rst = 1'b1;
        tick();

        load_word(0, 20'h11111);
        load_word(1, 20'h22222);
        load_word(2, 20'h33333);
        tick();

        // Free-run, 3 words
        do_start(3, 1'b0, e);
        push_run(e, 3, 1'b0, BIG, dc);
        wait_until(dc + 2);

        // Single-step with uneven pauses
        gap[0] = 1; gap[1] = 3;
        do_start(3, 1'b1, e);
        push_run(e, 3, 1'b1, BIG, dc);
        foreach (step_at[i]) begin
            wait_until(step_at[i] - 1);
            step = 1'b1;
            tick();
            step = 1'b0;
        end
        wait_until(dc + 2);

        // Abort during word 1, its second cycle
        do_start(3, 1'b0, e);
        push_run(e, 3, 1'b0, e + S + 1, dc);
        wait_until(e + S + 1);
        abort = 1'b1;
        push(e + S + 2, NOP, 0, 1'b0, 1'b0, 1'b1);
        push(e + S + 3, NOP, 0, 1'b0, 1'b0, 1'b0);
        push(e + S + 4, NOP, 0, 1'b0, 1'b0, 1'b0);
        tick();
        abort = 1'b0;
        wait_until(e + S + 5);

        // Abort and step together in PAUSE
        gap[0] = 2;
        do_start(3, 1'b1, e);
        push_run(e, 3, 1'b1, e + S, dc);
        wait_until(e + S);
        step  = 1'b1;
        abort = 1'b1;
        push(e + S + 1, NOP, 0, 1'b0, 1'b0, 1'b1);
        push(e + S + 2, NOP, 0, 1'b0, 1'b0, 1'b0);
        tick();
        step  = 1'b0;
        abort = 1'b0;
        wait_until(e + S + 3);

        // prog_len = 0
        do_start(0, 1'b0, e);
        push(e,     NOP, -1, 1'b0, 1'b1, 1'b0);
        push(e + 1, NOP, -1, 1'b0, 1'b0, 1'b0);
        wait_until(e + 2);

        // Load while busy is rejected
        do_start(3, 1'b0, e);
        push_run(e, 3, 1'b0, BIG, dc);
        wait_until(e + S + 1);
        load_en   = 1'b1;
        load_addr = 5'd1;
        load_data = 20'hBAD00;
        set_err(e + S + 2);
        tick();
        load_en = 1'b0;
        wait_until(dc + 2);

        // Rerun: mem[1] untouched; load and start in the same IDLE cycle
        load_en   = 1'b1;
        load_addr = 5'd0;
        load_data = 20'h44444;
        prog[0]   = 20'h44444;
        do_start(3, 1'b0, e);
        load_en = 1'b0;
        push_run(e, 3, 1'b0, BIG, dc);
        wait_until(dc + 2);

        // Reset asserted mid-run (during word 1), then retained program reruns
        do_start(3, 1'b0, e);
        push_run(e, 3, 1'b0, e + S - 1, dc);
        wait_until(e + S);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("midrst");
        tick(); tick();
        rst = 1'b1;
        tick();
        do_start(3, 1'b0, e);
        push_run(e, 3, 1'b0, BIG, dc);
        wait_until(dc + 2);

        // prog_len = 40 clamps to 32 words
        for (int i = 0; i < 32; i++) load_word(i, 20'hA0000 | IW'(i * 3 + 1));
        do_start(40, 1'b0, e);
        push_run(e, 32, 1'b0, BIG, dc);
        wait_until(dc + 2);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
